uart_rx_frame: RTL
==================

# uart_rx_frame

UART receive block: the far-end consumer of the serial line driven by the team's UART transmit path, and the decoder for that path's frame format. It oversamples the line by a programmable prescale and recovers start, data (LSB first), optional parity and stop bits. It delivers the parallel byte with a one-cycle valid strobe, or reports a parity or stop (framing) error. It sits between the pad-side RX line and the system register/FIFO interface.

## Interface
Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the Prescale input.

Ports:
- clk  input  1  single system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- RX_IN  input  1  asynchronous serial line, idle high.
- Prescale  input  PRESCALE_W  oversampling ratio. Legal values are 8, 16 and 32.
- PAR_EN  input  1  1 = a parity bit follows the data bits.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  last correctly received byte.
- Data_Valid  output  1  one-cycle strobe: P_DATA has been updated.
- parity_error  output  1  one-cycle strobe: the received parity did not match.
- stop_error  output  1  one-cycle strobe: the stop bit was sampled as 0.

## Operation
- RX_IN passes through a two-flop synchronizer. All logic below uses the synchronized value, rx_s.
- Counters:
  - edge_cnt counts oversample ticks, 0..Prescale-1.
  - bit_cnt counts data bits, 0..DATA_WIDTH-1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On rx_s = 0, go to START. That cycle is edge_cnt = 0.
  - At the same time, latch Prescale, PAR_EN and PAR_TYP. These latched values apply for the whole frame.
  - If Prescale is not 8, 16 or 32, stay in IDLE and ignore the line.
- Bit sampling: each bit takes three samples at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority vote of the three.
- START: at the end of the bit (edge_cnt = P-1):
  - sampled 0 → go to DATA.
  - sampled 1 → glitch; go to IDLE with no strobe.
- DATA:
  - Shift each sampled bit into a shift register, LSB first.
  - After bit DATA_WIDTH-1 ends, go to PARITY if the latched PAR_EN = 1, otherwise to STOP.
- PARITY:
  - Expected parity = XOR of the data bits, XOR the latched PAR_TYP.
  - A mismatch sets an internal par_fail flag.
  - At the end of the bit, go to STOP.
- STOP:
  - Sampled 0 sets an internal stop_fail flag.
  - At edge_cnt = P-1, register the frame result:
    - no failures → P_DATA <= shift register and Data_Valid <= 1;
    - otherwise parity_error <= par_fail and stop_error <= stop_fail. P_DATA is unchanged and Data_Valid stays 0.
    - Both error strobes may assert together.
  - Then go to IDLE.
- Back-to-back frames: IDLE sees the next start bit in the cycle after STOP ends. There are no dead cycles beyond the sampled line.
- P_DATA holds its value until the next good frame.

## Timing
- Reset values:
  - P_DATA = 0.
  - Data_Valid, parity_error and stop_error = 0.
  - State = IDLE; counters = 0; both synchronizer flops = 1.
- rst is sampled on clk. Asserting it mid-frame aborts the frame: no strobe is produced and the block is in IDLE on the next cycle.
- Frame length is N = 1 + DATA_WIDTH + PAR_EN + 1 bits.
- Strobe latency:
  - Strobes are high in cycle T0 + N*P, where T0 is the cycle in which IDLE observes rx_s = 0.
  - Measured from RX_IN, this is 2 cycles later, because of the synchronizer.
- Strobes last exactly one clock cycle.
- Changes to Prescale, PAR_EN or PAR_TYP during a frame take effect at the next start bit.
- A start bit that is low for less than about P/2 ticks is rejected in START, and nothing is reported.

## Test plan
- Reset, then P = 8, PAR_EN = 1, PAR_TYP = 0, send 0xA5 with parity bit 0 and stop 1. Required: Data_Valid pulses once, 88 cycles after the synchronized falling edge; P_DATA = 0xA5; no error strobes.
- Same setup with PAR_TYP = 1 and parity bit 0 sent. Required: parity_error pulses once; Data_Valid = 0; P_DATA keeps its previous value.
- P = 16, PAR_EN = 0, send 0x3C with stop bit 0. Required: stop_error pulses at T0 + 160; P_DATA is unchanged.
- P = 32, line low for 10 cycles then high. Required: the block returns to IDLE; no strobe. A following valid frame 0x81 is received correctly.
- Two back-to-back frames 0x12 and 0x34 at P = 8, PAR_EN = 0, with no idle time between them. Required: two Data_Valid pulses, 80 cycles apart, with P_DATA = 0x12 and then 0x34.
- Assert rst in the middle of DATA. Required: all outputs are 0 on the next cycle and no strobe fires; the next frame is received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 3-sample majority voting per bit at a programmable oversampling
// ratio; delivers a data byte or parity/stop error strobes once the stop bit ends.
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_ONE  = BIT_CNT_W'(1);
    localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    state_t                 state_next;

    logic                   rx_meta;
    logic                   rx_s;
    logic [PRESCALE_W-1:0]  prescale_lat;
    logic [PRESCALE_W-1:0]  edge_cnt;
    logic [PRESCALE_W-1:0]  half;
    logic                   par_en_lat;
    logic                   par_typ_lat;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [2:0]             samples;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic                   par_fail;

    logic                   prescale_ok;
    logic                   bit_end;
    logic                   last_data;
    logic                   bit_val;

    logic                   frame_start;
    logic                   take_sample;
    logic                   shift_bit;
    logic                   check_parity;
    logic                   finish_frame;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    assign prescale_ok = (Prescale == PRESCALE_W'(8)) ||
                         (Prescale == PRESCALE_W'(16)) ||
                         (Prescale == PRESCALE_W'(32));
    assign half      = prescale_lat >> 1;
    assign bit_end   = (edge_cnt == prescale_lat - ONE);
    assign last_data = (bit_cnt == LAST_BIT);
    assign bit_val   = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rx_s && prescale_ok) state_next = START;
            // A start bit that votes high was only a glitch on the line
            START:   if (bit_end) state_next = bit_val ? IDLE : DATA;
            DATA:    if (bit_end && last_data) state_next = par_en_lat ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        frame_start  = (state == IDLE) && !rx_s && prescale_ok;
        take_sample  = (state != IDLE) &&
                       ((edge_cnt == half - ONE) || (edge_cnt == half) ||
                        (edge_cnt == half + ONE));
        shift_bit    = (state == DATA) && bit_end;
        check_parity = (state == PARITY) && bit_end;
        finish_frame = (state == STOP) && bit_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_lat <= PRESCALE_W'(8);
            par_en_lat   <= 1'b0;
            par_typ_lat  <= 1'b0;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            samples      <= '1;
            shift_reg    <= '0;
            par_fail     <= 1'b0;
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            Data_Valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;

            // The detecting cycle counts as tick 0 of the start bit
            if (frame_start) begin
                prescale_lat <= Prescale;
                par_en_lat   <= PAR_EN;
                par_typ_lat  <= PAR_TYP;
                edge_cnt     <= ONE;
                bit_cnt      <= '0;
                par_fail     <= 1'b0;
            end else if (state == IDLE) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
            end

            if (take_sample) begin
                samples <= {samples[1:0], rx_s};
            end

            if (shift_bit) begin
                shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                bit_cnt   <= last_data ? '0 : bit_cnt + BIT_ONE;
            end

            if (check_parity) begin
                par_fail <= (bit_val != ((^shift_reg) ^ par_typ_lat));
            end

            if (finish_frame) begin
                if (!par_fail && bit_val) begin
                    P_DATA     <= shift_reg;
                    Data_Valid <= 1'b1;
                end else begin
                    parity_error <= par_fail;
                    stop_error   <= !bit_val;
                end
            end
        end
    end

endmodule
